// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and its requesters.
// The sequencer uses the slave modport and requesters use the master modport.
interface reset_sequencer_if #(
    parameter int NUM_DOM = 4
);
    logic [NUM_DOM-1:0] soft_req;
    logic               soft_all;
    logic [NUM_DOM-1:0] rst_out;
    logic [NUM_DOM-1:0] soft_ack;
    logic               seq_busy;
    logic               ready;

    modport master (
        output soft_req,
        output soft_all,
        input  rst_out,
        input  soft_ack,
        input  seq_busy,
        input  ready
    );

    modport slave (
        input  soft_req,
        input  soft_all,
        output rst_out,
        output soft_ack,
        output seq_busy,
        output ready
    );
endinterface

// File: rtl/reset_sequencer.sv
// Central reset controller: synchronised board-reset release, staggered per-domain
// release, per-domain soft-reset pulses and full-chip soft reset.
module reset_sequencer #(
    parameter int NUM_DOM   = 4,
    parameter int HOLD_CYC  = 8,
    parameter int PULSE_CYC = 4
) (
    input logic              clk,
    input logic              reset,
    reset_sequencer_if.slave bus
);
    localparam int MAX_CYC = (HOLD_CYC > PULSE_CYC) ? HOLD_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    typedef enum logic [1:0] {SEQ, RUN, SOFT} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n, low;
    logic [NUM_DOM-1:0] rst_q, rst_n, ack_q, ack_n;
    logic [1:0]         sync;
    logic               rst_i;

    // Release synchroniser: asserts with reset, lets go two edges after it falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], 1'b1};
    end

    assign rst_i = ~sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEQ;
            cnt   <= '0;
            idx   <= '0;
            rst_q <= '1;
            ack_q <= '0;
        end else if (rst_i) begin
            state <= SEQ;
            cnt   <= '0;
            idx   <= '0;
            rst_q <= '1;
            ack_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            rst_q <= rst_n;
            ack_q <= ack_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rst_n   = rst_q;
        ack_n   = '0;
        low     = '0;
        // Fixed priority: lowest requesting index wins.
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (bus.soft_req[i]) low = IDX_W'(i);
        end
        case (state)
            SEQ: begin
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    rst_n[idx] = 1'b0;
                    cnt_n      = '0;
                    if (idx == IDX_W'(NUM_DOM - 1)) begin
                        idx_n   = '0;
                        state_n = RUN;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (bus.soft_all) begin
                    rst_n   = '1;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = SEQ;
                end else if (|bus.soft_req) begin
                    rst_n[low] = 1'b1;
                    idx_n      = low;
                    cnt_n      = '0;
                    state_n    = SOFT;
                end
            end
            SOFT: begin
                if (cnt == CNT_W'(PULSE_CYC - 1)) begin
                    rst_n[idx] = 1'b0;
                    ack_n[idx] = 1'b1;
                    cnt_n      = '0;
                    idx_n      = '0;
                    state_n    = RUN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = SEQ;
        endcase
    end

    assign bus.rst_out  = rst_q;
    assign bus.soft_ack = ack_q;
    assign bus.seq_busy = (state != RUN);
    assign bus.ready    = (state != SEQ);
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: power-up timing, async reset mid-sequence, soft-reset
// pulses, priority, full-chip soft reset and requests arriving while busy.
module tb_reset_sequencer;
    localparam int HOLD = 8;

    typedef struct packed {
        logic [3:0] rst;
        logic [3:0] ack;
        logic       busy;
        logic       ready;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] rst;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  sb[$];
    string sb_name[$];
    vec_t  vecs[$];

    reset_sequencer_if #(.NUM_DOM(4)) bus ();

    reset_sequencer #(
        .NUM_DOM  (4),
        .HOLD_CYC (8),
        .PULSE_CYC(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] seqRst(input int t);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (t < (k + 1) * HOLD);
        return r;
    endfunction

    task automatic compareField(input string name, input string field,
                                input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s.%s actual=%b expected=%b", name, field, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t  e;
        string nm;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard actual=empty expected=entry");
            return;
        end
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        compareField(nm, "rst_out", bus.rst_out, e.rst);
        compareField(nm, "soft_ack", bus.soft_ack, e.ack);
        compareField(nm, "seq_busy", {3'b000, bus.seq_busy}, {3'b000, e.busy});
        compareField(nm, "ready", {3'b000, bus.ready}, {3'b000, e.ready});
    endtask

    // Drives inputs at the falling edge, records the outcome expected after the next rising edge.
    task automatic applyStimulus(input string name, input logic [3:0] req, input logic all,
                                 input exp_t e);
        bus.soft_req = req;
        bus.soft_all = all;
        sb.push_back(e);
        sb_name.push_back(name);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runSequence(input string name, input int from, input int to,
                               input logic [3:0] req);
        for (int t = from; t <= to; t++) begin
            applyStimulus($sformatf("%s[t=%0d]", name, t), req, 1'b0,
                          '{rst: seqRst(t), ack: 4'b0000, busy: (t < 4 * HOLD),
                            ready: (t >= 4 * HOLD)});
            checkOutput();
        end
    endtask

    task automatic addVec(input logic [3:0] req, input logic [3:0] rst,
                          input logic [3:0] ack, input logic busy);
        vecs.push_back('{req: req, rst: rst, ack: ack, busy: busy});
    endtask

    initial begin
        reset        = 1'b1;
        bus.soft_req = 4'b0000;
        bus.soft_all = 1'b0;

        // Single 1-cycle request on domain 2.
        addVec(4'b0100, 4'b0100, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0100, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0100, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0100, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0000, 4'b0100, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Domains 1 and 3 together, each dropped after its ack.
        addVec(4'b1010, 4'b0010, 4'b0000, 1'b1);
        repeat (3) addVec(4'b1010, 4'b0010, 4'b0000, 1'b1);
        addVec(4'b1010, 4'b0000, 4'b0010, 1'b0);
        addVec(4'b1000, 4'b1000, 4'b0000, 1'b1);
        repeat (3) addVec(4'b1000, 4'b1000, 4'b0000, 1'b1);
        addVec(4'b1000, 4'b0000, 4'b1000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Domain 2 pulsed once mid-pulse of domain 0: ignored.
        addVec(4'b0001, 4'b0001, 4'b0000, 1'b1);
        addVec(4'b0101, 4'b0001, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0001, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0001, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0000, 4'b0001, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Domain 2 held through domain 0's pulse: served right after the ack.
        addVec(4'b0001, 4'b0001, 4'b0000, 1'b1);
        repeat (3) addVec(4'b0101, 4'b0001, 4'b0000, 1'b1);
        addVec(4'b0101, 4'b0000, 4'b0001, 1'b0);
        addVec(4'b0100, 4'b0100, 4'b0000, 1'b1);
        repeat (3) addVec(4'b0100, 4'b0100, 4'b0000, 1'b1);
        addVec(4'b0100, 4'b0000, 4'b0100, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        sb.push_back('{rst: 4'hF, ack: 4'h0, busy: 1'b1, ready: 1'b0});
        sb_name.push_back("in_reset");
        checkOutput();

        reset = 1'b0;
        runSequence("powerup", -1, 20, 4'b0000);

        #2 reset = 1'b1;
        #1;
        sb.push_back('{rst: 4'hF, ack: 4'h0, busy: 1'b1, ready: 1'b0});
        sb_name.push_back("async_reset");
        checkOutput();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        runSequence("restart", -1, 4 * HOLD, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].req, 1'b0,
                          '{rst: vecs[i].rst, ack: vecs[i].ack, busy: vecs[i].busy, ready: 1'b1});
            checkOutput();
        end

        applyStimulus("soft_all", 4'b0001, 1'b1,
                      '{rst: 4'hF, ack: 4'h0, busy: 1'b1, ready: 1'b0});
        checkOutput();
        runSequence("allseq", 1, 4 * HOLD, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("held0_%0d", i), 4'b0001, 1'b0,
                          '{rst: 4'b0001, ack: 4'h0, busy: 1'b1, ready: 1'b1});
            checkOutput();
        end
        applyStimulus("held0_ack", 4'b0001, 1'b0,
                      '{rst: 4'b0000, ack: 4'b0001, busy: 1'b0, ready: 1'b1});
        checkOutput();
        applyStimulus("idle_end", 4'b0000, 1'b0,
                      '{rst: 4'b0000, ack: 4'b0000, busy: 1'b0, ready: 1'b1});
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
